// File: rtl/gpio_iop_arbiter_if.sv
// gpio_iop_arbiter_if: IOP transfer bus between one driver and one responder.
// The master side drives select/transfer/payload, the slave side answers with
// read data, ready and an error response. Used for both requester ports and
// the target port of gpio_iop_arbiter.
interface gpio_iop_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              iosel;
  logic              iotrans;
  logic              iowrite;
  logic [1:0]        iosize;
  logic [ADDR_W-1:0] ioaddr;
  logic [31:0]       iowdata;
  logic [31:0]       iordata;
  logic              ready;
  logic              resp;

  modport master (
    output iosel, iotrans, iowrite, iosize, ioaddr, iowdata,
    input  iordata, ready, resp
  );

  modport slave (
    input  iosel, iotrans, iowrite, iosize, ioaddr, iowdata,
    output iordata, ready, resp
  );
endinterface

// File: rtl/gpio_iop_arbiter.sv
// gpio_iop_arbiter: round-robin arbiter letting two IOP requesters share one
// target. The owner's payload is steered combinationally to the target and
// the target's completion is steered back to the owner only; the payload is
// never registered, so requesters hold their inputs until ready.
// Build macro GPIO_ARB_TIMEOUT_EN: when defined, a wait-limit counter forces
// an error completion after TIMEOUT_CYCLES owned cycles without target ready.
module gpio_iop_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  gpio_iop_arbiter_if.slave         m0,
  gpio_iop_arbiter_if.slave         m1,
  gpio_iop_arbiter_if.master        s,
  output logic [1:0]                GRANT
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t     state_r;
  logic       last_r;
  logic [1:0] grant_r;

  logic       req0_s;
  logic       req1_s;
  logic       own0_s;
  logic       own1_s;
  logic       tmo_s;
  logic       done0_s;
  logic       done1_s;

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_r;
`endif

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("gpio_iop_arbiter: TIMEOUT_CYCLES must lie in 2..255");
  end

  // Decode requests, current ownership and completion of the owned transfer
  always_comb begin
    req0_s = m0.iosel & m0.iotrans;
    req1_s = m1.iosel & m1.iotrans;
    own0_s = (state_r == OWN0);
    own1_s = (state_r == OWN1);
`ifdef GPIO_ARB_TIMEOUT_EN
    tmo_s  = (own0_s | own1_s) & ~s.ready & (cnt_r == TMO_LAST);
`else
    tmo_s  = 1'b0;
`endif
    // A dropped request never completes, even if the target is ready
    done0_s = own0_s & req0_s & (s.ready | tmo_s);
    done1_s = own1_s & req1_s & (s.ready | tmo_s);
  end

  // Ownership FSM: round-robin grant from IDLE, back to IDLE after each transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      grant_r <= 2'b00;
`ifdef GPIO_ARB_TIMEOUT_EN
      cnt_r   <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          // Requester 0 wins alone, or on a tie when requester 1 went last
          if (req0_s && (!req1_s || last_r)) begin
            state_r <= OWN0;
            last_r  <= 1'b0;
            grant_r <= 2'b01;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt_r   <= 8'd0;
`endif
          end else if (req1_s) begin
            state_r <= OWN1;
            last_r  <= 1'b1;
            grant_r <= 2'b10;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt_r   <= 8'd0;
`endif
          end else begin
            state_r <= IDLE;
            grant_r <= 2'b00;
          end
        end
        OWN0: begin
          if (!req0_s || done0_s) begin
            state_r <= IDLE;
            grant_r <= 2'b00;
          end else begin
            state_r <= OWN0;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt_r   <= cnt_r + 8'd1;
`endif
          end
        end
        OWN1: begin
          if (!req1_s || done1_s) begin
            state_r <= IDLE;
            grant_r <= 2'b00;
          end else begin
            state_r <= OWN1;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt_r   <= cnt_r + 8'd1;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 2'b00;
        end
      endcase
    end
  end

  // Steer the owner's controls and payload to the target; all zero when idle
  always_comb begin
    case (state_r)
      OWN0: begin
        s.iosel   = m0.iosel;
        s.iotrans = m0.iotrans;
        s.iowrite = m0.iowrite;
        s.iosize  = m0.iosize;
        s.ioaddr  = m0.ioaddr;
        s.iowdata = m0.iowdata;
      end
      OWN1: begin
        s.iosel   = m1.iosel;
        s.iotrans = m1.iotrans;
        s.iowrite = m1.iowrite;
        s.iosize  = m1.iosize;
        s.ioaddr  = m1.ioaddr;
        s.iowdata = m1.iowdata;
      end
      default: begin
        s.iosel   = 1'b0;
        s.iotrans = 1'b0;
        s.iowrite = 1'b0;
        s.iosize  = 2'b00;
        s.ioaddr  = {ADDR_W{1'b0}};
        s.iowdata = 32'h0000_0000;
      end
    endcase
  end

  // Return the completion to the owner only; a timeout reads as error with zero data
  always_comb begin
    m0.ready = done0_s;
    m1.ready = done1_s;
    if (done0_s && s.ready) begin
      m0.iordata = s.iordata;
      m0.resp    = s.resp;
    end else if (done0_s) begin
      m0.iordata = 32'h0000_0000;
      m0.resp    = 1'b1;
    end else begin
      m0.iordata = 32'h0000_0000;
      m0.resp    = 1'b0;
    end
    if (done1_s && s.ready) begin
      m1.iordata = s.iordata;
      m1.resp    = s.resp;
    end else if (done1_s) begin
      m1.iordata = 32'h0000_0000;
      m1.resp    = 1'b1;
    end else begin
      m1.iordata = 32'h0000_0000;
      m1.resp    = 1'b0;
    end
  end

  assign GRANT = grant_r;

endmodule

// File: tb/tb_gpio_iop_arbiter.sv
// tb_gpio_iop_arbiter: scoreboard bench for gpio_iop_arbiter. Stimulus rounds
// predict grant order, completion cycle and response from the arbitration
// rules and push them into a queue; a monitor pops on every requester ready.
module tb_gpio_iop_arbiter;
  localparam int ADDR_W = 12;
  localparam int TMO    = 16;

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b0;
  logic [1:0] GRANT;

  gpio_iop_arbiter_if #(.ADDR_W(ADDR_W)) m0 ();
  gpio_iop_arbiter_if #(.ADDR_W(ADDR_W)) m1 ();
  gpio_iop_arbiter_if #(.ADDR_W(ADDR_W)) s ();

  gpio_iop_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .m0(m0.slave), .m1(m1.slave),
    .s(s.master), .GRANT(GRANT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          who;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic        resp;
    int          cyc;
  } exp_t;

  typedef struct {
    int          w;
    logic [31:0] rdata;
    logic        resp;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  bit    last_m = 1'b1;

  logic        pw    [2];
  logic [11:0] pa    [2];
  logic [31:0] pd    [2];
  logic [1:0]  ps    [2];
  int          pwait [2];
  logic [31:0] prd   [2];
  logic        presp [2];

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int lat_of(input int w);
`ifdef GPIO_ARB_TIMEOUT_EN
    return (w > TMO - 1) ? TMO - 1 : w;
`else
    return w;
`endif
  endfunction

  task automatic rand_payload(input int n);
    pw[n]    = 1'($urandom_range(0, 1));
    pa[n]    = 12'($urandom);
    pd[n]    = $urandom;
    ps[n]    = 2'($urandom_range(0, 3));
    pwait[n] = $urandom_range(0, 4);
    prd[n]   = $urandom;
    presp[n] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input int n, input logic sel, input logic trans);
    if (n == 0) begin
      m0.iosel = sel; m0.iotrans = trans; m0.iowrite = pw[0];
      m0.iosize = ps[0]; m0.ioaddr = pa[0]; m0.iowdata = pd[0];
    end else begin
      m1.iosel = sel; m1.iotrans = trans; m1.iowrite = pw[1];
      m1.iosize = ps[1]; m1.ioaddr = pa[1]; m1.iowdata = pd[1];
    end
  endtask

  // Predict one transfer of requester n whose ownership starts in cycle start
  task automatic expect_txn(input int n, input int start, output int done_c);
    exp_t  e;
    plan_t p;
    int    lat;
    bit    to;
    lat     = lat_of(pwait[n]);
    to      = (lat != pwait[n]);
    e.who   = n;
    e.wr    = pw[n];
    e.addr  = pa[n];
    e.wdata = pd[n];
    e.size  = ps[n];
    e.rdata = to ? 32'h0 : prd[n];
    e.resp  = to ? 1'b1 : presp[n];
    e.cyc   = start + lat;
    p.w     = pwait[n];
    p.rdata = prd[n];
    p.resp  = presp[n];
    exp_q.push_back(e);
    plan_q.push_back(p);
    done_c  = e.cyc;
  endtask

  task automatic wait_done(input int n);
    int t;
    bit seen;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 100) begin
      @(negedge HCLK);
      seen = (n == 0) ? m0.ready : m1.ready;
      t++;
    end
    if (!seen) check($sformatf("ready_wait_m%0d", n), 64'd0, 64'd1);
    @(posedge HCLK); #1;
    drive(n, 1'b0, 1'b0);
  endtask

  // One round: the chosen requesters assert in the same cycle
  task automatic run_round(input bit r0, input bit r1);
    int  k, d, d2, first;
    logic sel;
    @(posedge HCLK); #1;
    k = cyc;
    if (r0 && r1) begin
      first = last_m ? 0 : 1;
      expect_txn(first, k + 1, d);
      expect_txn(1 - first, d + 2, d2);
      last_m = ((1 - first) == 1);
    end else begin
      first = r0 ? 0 : 1;
      expect_txn(first, k + 1, d);
      last_m = (first == 1);
    end
    for (int n = 0; n < 2; n++) begin
      if ((n == 0) ? r0 : r1) drive(n, 1'b1, 1'b1);
      else begin
        sel = 1'($urandom_range(0, 1));
        drive(n, sel, ~sel);
      end
    end
    fork
      begin if (r0) wait_done(0); end
      begin if (r1) wait_done(1); end
    join
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    check("grant_after_round", 64'(GRANT), 64'd0);
  endtask

  // Target model: follows the plan queue, one plan per started transfer
  task automatic target_loop();
    bit    active;
    int    n;
    plan_t p;
    active = 1'b0; n = 0;
    p.w = 1000; p.rdata = 32'h0; p.resp = 1'b0;
    s.ready = 1'b0; s.iordata = 32'h0; s.resp = 1'b0;
    forever begin
      @(posedge HCLK); #2;
      if (s.iosel && s.iotrans) begin
        if (!active) begin
          active = 1'b1;
          n = 0;
          if (plan_q.size() == 0) begin
            check("plan_underflow", 64'd1, 64'd0);
            p.w = 1000;
          end else p = plan_q.pop_front();
        end else n++;
        s.ready   = (n == p.w);
        s.iordata = (n == p.w) ? p.rdata : $urandom;
        s.resp    = (n == p.w) ? p.resp : 1'($urandom_range(0, 1));
      end else begin
        active    = 1'b0;
        s.ready   = 1'($urandom_range(0, 1));
        s.iordata = $urandom;
        s.resp    = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Monitor: non-owner stays quiet; every ready pops and checks the scoreboard
  task automatic monitor();
    exp_t e;
    int   who;
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        if (!GRANT[0]) check("m0_nonowner", {m0.ready, m0.resp, m0.iordata}, 64'd0);
        if (!GRANT[1]) check("m1_nonowner", {m1.ready, m1.resp, m1.iordata}, 64'd0);
        if (m0.ready || m1.ready) begin
          who = m0.ready ? 0 : 1;
          check("dual_ready", 64'(m0.ready & m1.ready), 64'd0);
          if (exp_q.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check("ready_owner", 64'(who), 64'(e.who));
            check("ready_cycle", 64'(cyc), 64'(e.cyc));
            check("grant_at_ready", 64'(GRANT), 64'(2'b01 << e.who));
            check("s_sel_trans", 64'({s.iosel, s.iotrans}), 64'd3);
            check("s_iowrite", 64'(s.iowrite), 64'(e.wr));
            check("s_ioaddr", 64'(s.ioaddr), 64'(e.addr));
            check("s_iowdata", 64'(s.iowdata), 64'(e.wdata));
            check("s_iosize", 64'(s.iosize), 64'(e.size));
            check("rdata", 64'((who == 0) ? m0.iordata : m1.iordata), 64'(e.rdata));
            check("resp", 64'((who == 0) ? m0.resp : m1.resp), 64'(e.resp));
          end
        end
      end
    end
  endtask

  initial begin
    int k, d, r;
    for (int n = 0; n < 2; n++) begin
      rand_payload(n);
      drive(n, 1'b0, 1'b0);
    end
    fork
      monitor();
      target_loop();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    #3;
    check("rst_grant", 64'(GRANT), 64'd0);
    check("rst_s_ctrl", 64'({s.iosel, s.iotrans, s.iowrite}), 64'd0);
    check("rst_s_payload", 64'({s.iosize, s.ioaddr, s.iowdata}), 64'd0);
    check("rst_ready_resp", 64'({m0.ready, m0.resp, m1.ready, m1.resp}), 64'd0);
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Tie right after reset: requester 0 first, one idle cycle, then requester 1
    rand_payload(0); rand_payload(1);
    pwait[0] = 0; pwait[1] = 0;
    run_round(1'b1, 1'b1);

    // Requester 0 write, zero-wait target
    rand_payload(0);
    pw[0] = 1'b1; pa[0] = 12'h004; pd[0] = 32'h0000_A5A5; pwait[0] = 0; presp[0] = 1'b0;
    run_round(1'b1, 1'b0);

    // Requester 1 read with three wait cycles
    rand_payload(1);
    pw[1] = 1'b0; pa[1] = 12'h000; pwait[1] = 3; prd[1] = 32'h0000_1234; presp[1] = 1'b0;
    run_round(1'b0, 1'b1);

    // Randomized rounds
    repeat (40) begin
      rand_payload(0); rand_payload(1);
      r = $urandom_range(1, 3);
      run_round(r[0], r[1]);
    end

`ifdef GPIO_ARB_TIMEOUT_EN
    // Target never ready: forced error completion in the last allowed cycle
    rand_payload(0);
    pwait[0] = 40;
    run_round(1'b1, 1'b0);
`endif

    // Owner drops its request before ready: back to idle, no ready
    rand_payload(0);
    pwait[0] = 50;
    @(posedge HCLK); #1;
    expect_txn(0, 0, d);
    void'(exp_q.pop_back());
    drive(0, 1'b1, 1'b1);
    @(posedge HCLK); #1;
    check("viol_grant_own", 64'(GRANT), 64'd1);
    @(posedge HCLK); #1;
    drive(0, 1'b0, 1'b0);
    @(posedge HCLK); #1;
    check("viol_grant_idle", 64'(GRANT), 64'd0);
    check("viol_s_iotrans", 64'(s.iotrans), 64'd0);
    last_m = 1'b0;

    // Reset while requester 1 owns the target, then a fresh grant after release
    rand_payload(1);
    pwait[1] = 50;
    @(posedge HCLK); #1;
    expect_txn(1, 0, d);
    void'(exp_q.pop_back());
    drive(1, 1'b1, 1'b1);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    check("pre_rst_grant", 64'(GRANT), 64'd2);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_mid_grant", 64'(GRANT), 64'd0);
    check("rst_mid_s_iosel", 64'(s.iosel), 64'd0);
    check("rst_mid_ready", 64'(m1.ready), 64'd0);
    last_m = 1'b1;
    @(posedge HCLK);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    k = cyc;
    pwait[1] = 1;
    prd[1] = $urandom;
    expect_txn(1, k + 1, d);
    wait_done(1);
    check("post_rst_grant_idle", 64'(GRANT), 64'd0);

    repeat (3) @(posedge HCLK);
    #1;
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("plan_queue_drained", 64'(plan_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
